demux16_deser: RTL and testbench

Bit-serial to 16-bit parallel demultiplexer. It is the receive-side counterpart of the 16:1 bit-select mux used for serialising a word by stepping the select from 0 to 15.
- Each accepted serial bit is routed to the next output lane, starting at lane 0.
- A completed word is presented on a valid/ready output port.
- It is double-buffered, so a new frame can be assembled while the previous word waits to be taken.

---
 rtl/demux16_deser_if.sv | 31 +++
 rtl/demux16_deser.sv | 112 +++++++++++
 tb/tb_demux16_deser.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux16_deser_if.sv
// demux16_deser_if: bundles the serial input handshake, the parallel output
// handshake and the status outputs of the bit-serial deserialiser.
//   in_valid/in_bit/in_sof -> serial bit stream, in_ready <- backpressure
//   dout/dout_valid        <- assembled word, dout_ready -> consumer take
//   lane_sel/slot_strobe/frame_err <- lane position and status
// slave modport is the deserialiser side; master is the producer/consumer side.
interface demux16_deser_if #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
);
  logic             in_valid;
  logic             in_bit;
  logic             in_sof;
  logic             in_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             dout_ready;
  logic [SEL_W-1:0] lane_sel;
  logic [WIDTH-1:0] slot_strobe;
  logic             frame_err;

  modport slave (
    input  in_valid, in_bit, in_sof, dout_ready,
    output in_ready, dout, dout_valid, lane_sel, slot_strobe, frame_err
  );

  modport master (
    output in_valid, in_bit, in_sof, dout_ready,
    input  in_ready, dout, dout_valid, lane_sel, slot_strobe, frame_err
  );
endinterface

// File: rtl/demux16_deser.sv
// demux16_deser: bit-serial to WIDTH-bit parallel demultiplexer.
// Each accepted bit is routed to the next lane (LSB first). A completed word
// moves to the output register; if that register still holds an untaken word,
// the completed word is parked in the assembly register and input is stalled.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - demux16_deser_if.slave (serial in, parallel out, status)
module demux16_deser #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  demux16_deser_if.slave  bus
);

  logic [WIDTH-1:0] asm_q, asm_d;
  logic [SEL_W-1:0] lane_q, lane_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             asm_full_q, asm_full_d;
  logic [WIDTH-1:0] strobe_q, strobe_d;
  logic             frame_err_q, frame_err_d;

  logic             accept;
  logic             take;
  logic             complete;
  logic [WIDTH-1:0] word;
  logic [SEL_W-1:0] wr_lane;

  always_comb begin
    accept       = bus.in_valid & ~asm_full_q;
    take         = dout_valid_q & bus.dout_ready;
    asm_d        = asm_q;
    lane_d       = lane_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    asm_full_d   = asm_full_q;
    strobe_d     = '0;
    frame_err_d  = frame_err_q;
    complete     = 1'b0;
    word         = asm_q;
    wr_lane      = lane_q;

    if (accept) begin
      if (bus.in_sof) begin
        // Resync: restart the frame at lane 0; a nonzero lane means the
        // partial frame in progress is being thrown away.
        word     = '0;
        word[0]  = bus.in_bit;
        wr_lane  = '0;
        lane_d   = SEL_W'(1);
        if (lane_q != '0) frame_err_d = 1'b1;
      end else begin
        word          = asm_q;
        word[lane_q]  = bus.in_bit;
        lane_d        = lane_q + SEL_W'(1);
        complete      = (lane_q == SEL_W'(WIDTH - 1));
      end
      strobe_d[wr_lane] = 1'b1;
      asm_d             = word;
    end

    if (complete) begin
      // Output register free (or being freed this cycle): publish directly so
      // consecutive frames stream without a bubble; otherwise park the word.
      if (!dout_valid_q || take) begin
        dout_d       = word;
        dout_valid_d = 1'b1;
      end else begin
        asm_full_d = 1'b1;
      end
    end else if (take) begin
      if (asm_full_q) begin
        dout_d     = asm_q;
        asm_full_d = 1'b0;
        lane_d     = '0;
      end else begin
        dout_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q        <= '0;
      lane_q       <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      asm_full_q   <= 1'b0;
      strobe_q     <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      lane_q       <= lane_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      asm_full_q   <= asm_full_d;
      strobe_q     <= strobe_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.in_ready    = ~asm_full_q;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.lane_sel    = lane_q;
  assign bus.slot_strobe = strobe_q;
  assign bus.frame_err   = frame_err_q;

endmodule

// File: tb/tb_demux16_deser.sv
// tb_demux16_deser: self-checking bench for demux16_deser. Expected words are
// queued when a frame is sent and compared when the consumer takes dout.
module tb_demux16_deser;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  int   exp_lane = 0;
  logic [15:0] sbq[$];

  demux16_deser_if bus ();

  demux16_deser dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Output monitor: a take happens on the next rising edge.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.dout_valid === 1'b1 && bus.dout_ready === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL take_unexpected: dout=%h taken with no word expected", bus.dout);
      end else begin
        logic [15:0] e;
        e = sbq.pop_front();
        if (bus.dout !== e) begin
          errors++;
          $display("FAIL take_word: dout=%h required %h", bus.dout, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic send_bit(input logic b, input logic sof);
    logic r;
    int   budget;
    logic [15:0] es;
    bus.in_valid = 1'b1;
    bus.in_bit   = b;
    bus.in_sof   = sof;
    budget = 0;
    r = 1'b0;
    do begin
      @(negedge clk);
      r = bus.in_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!r && budget < 50);
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    checks++;
    if (r !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1", r);
    end else begin
      if (sof) exp_lane = 0;
      es = 16'(1) << exp_lane;
      checks++;
      if (bus.slot_strobe !== es) begin
        errors++;
        $display("FAIL slot_strobe: got %h required %h", bus.slot_strobe, es);
      end
      exp_lane = (exp_lane + 1) % 16;
      checks++;
      if (bus.lane_sel !== 4'(exp_lane)) begin
        errors++;
        $display("FAIL lane_sel: got %0d required %0d", bus.lane_sel, exp_lane);
      end
    end
  endtask

  task automatic send_word(input logic [15:0] w, input logic sof_first);
    sbq.push_back(w);
    for (int i = 0; i < 16; i++) send_bit(w[i], (i == 0) ? sof_first : 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_bit = 1'b0; bus.in_sof = 1'b0; bus.dout_ready = 1'b0;
    #13;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.dout_valid !== 1'b0 || bus.lane_sel !== 4'd0 ||
        bus.slot_strobe !== 16'h0 || bus.frame_err !== 1'b0 || bus.dout !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b vld=%b lane=%0d strb=%h err=%b dout=%h required 1 0 0 0000 0 0000",
               bus.in_ready, bus.dout_valid, bus.lane_sel, bus.slot_strobe, bus.frame_err, bus.dout);
    end
    rst = 1'b0;
    exp_lane = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_frame();
    bus.dout_ready = 1'b1;
    send_word(16'h5C9A, 1'b0);
    checks++;
    if (bus.dout_valid !== 1'b1 || bus.dout !== 16'h5C9A || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL basic_frame: vld=%b dout=%h err=%b required 1 5c9a 0",
               bus.dout_valid, bus.dout, bus.frame_err);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.slot_strobe !== 16'h0) begin
      errors++;
      $display("FAIL basic_idle: vld=%b strb=%h required 0 0000", bus.dout_valid, bus.slot_strobe);
    end
  endtask

  task automatic test_backpressure_stall();
    bus.dout_ready = 1'b0;
    send_word(16'h1234, 1'b0);
    send_word(16'hABCD, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.dout !== 16'h1234 || bus.dout_valid !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_full: rdy=%b dout=%h vld=%b required 0 1234 1",
               bus.in_ready, bus.dout, bus.dout_valid);
    end
    // 17th bit held while stalled
    bus.in_valid = 1'b1; bus.in_bit = 1'b1; bus.in_sof = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.slot_strobe !== 16'h0 || bus.lane_sel !== 4'd0) begin
        errors++;
        $display("FAIL stall_no_write: strb=%h lane=%0d required 0000 0", bus.slot_strobe, bus.lane_sel);
      end
    end
    bus.dout_ready = 1'b1;
    @(posedge clk); #1;
    bus.dout_ready = 1'b0;
    checks++;
    if (bus.dout !== 16'hABCD || bus.dout_valid !== 1'b1 || bus.in_ready !== 1'b1 || bus.lane_sel !== 4'd0) begin
      errors++;
      $display("FAIL backpressure_release: dout=%h vld=%b rdy=%b lane=%0d required abcd 1 1 0",
               bus.dout, bus.dout_valid, bus.in_ready, bus.lane_sel);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.slot_strobe !== 16'h0001 || bus.lane_sel !== 4'd1) begin
      errors++;
      $display("FAIL stall_accept: strb=%h lane=%0d required 0001 1", bus.slot_strobe, bus.lane_sel);
    end
    exp_lane = 1;
    bus.dout_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain: vld=%b required 0", bus.dout_valid);
    end
  endtask

  task automatic test_resync();
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    checks++;
    if (bus.lane_sel !== 4'd5 || bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL resync_pre: lane=%0d err=%b required 5 0", bus.lane_sel, bus.frame_err);
    end
    send_word(16'hFFFF, 1'b1);
    checks++;
    if (bus.dout !== 16'hFFFF || bus.dout_valid !== 1'b1 || bus.frame_err !== 1'b1) begin
      errors++;
      $display("FAIL resync_word: dout=%h vld=%b err=%b required ffff 1 1",
               bus.dout, bus.dout_valid, bus.frame_err);
    end
    send_word(16'h00A5, 1'b1);
    checks++;
    if (bus.dout !== 16'h00A5 || bus.frame_err !== 1'b1) begin
      errors++;
      $display("FAIL clean_sof: dout=%h err=%b required 00a5 1", bus.dout, bus.frame_err);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    bus.dout_ready = 1'b0;
    send_word(16'h3C3C, 1'b0);
    for (int i = 0; i < 9; i++) send_bit(i[0], 1'b0);
    checks++;
    if (bus.lane_sel !== 4'd9 || bus.dout_valid !== 1'b1 || bus.frame_err !== 1'b1) begin
      errors++;
      $display("FAIL async_pre: lane=%0d vld=%b err=%b required 9 1 1",
               bus.lane_sel, bus.dout_valid, bus.frame_err);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.dout_valid !== 1'b0 || bus.lane_sel !== 4'd0 || bus.frame_err !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset: vld=%b lane=%0d err=%b rdy=%b required 0 0 0 1",
               bus.dout_valid, bus.lane_sel, bus.frame_err, bus.in_ready);
    end
    sbq.delete();
    exp_lane = 0;
    #3;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int   pulses[$];
    logic dropped;
    bus.dout_ready = 1'b1;
    dropped = 1'b0;
    fork
      begin
        send_word(16'h0000, 1'b0);
        send_word(16'hFFFF, 1'b0);
        send_word(16'h8001, 1'b0);
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(negedge clk);
          if (bus.in_ready !== 1'b1) dropped = 1'b1;
          if (bus.dout_valid === 1'b1) pulses.push_back(c);
        end
      end
    join
    checks++;
    if (dropped !== 1'b0) begin
      errors++;
      $display("FAIL b2b_in_ready: dropped=%b required 0", dropped);
    end
    checks++;
    if (pulses.size() != 3) begin
      errors++;
      $display("FAIL b2b_pulses: count=%0d required 3", pulses.size());
    end else begin
      checks++;
      if (pulses[1] - pulses[0] != 16 || pulses[2] - pulses[1] != 16) begin
        errors++;
        $display("FAIL b2b_spacing: gaps=%0d,%0d required 16,16",
                 pulses[1] - pulses[0], pulses[2] - pulses[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure_stall();
    test_resync();
    test_async_reset();
    test_back_to_back();
    @(posedge clk); #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: %0d words never taken, required 0", sbq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
